// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: command, ROM-read and LCD-write signals of the sprite blitter.
// Revision 1.0
`default_nettype none

interface sprite_blitter_if;
   logic        i_start;
   logic [3:0]  i_sprite_id;
   logic [7:0]  i_x_pos;
   logic [8:0]  i_y_pos;
   logic        o_busy;
   logic        o_done;

   logic [3:0]  o_rom_id;
   logic [15:0] o_rom_addr;
   logic [15:0] i_rom_data;

   logic [7:0]  o_pixel_x;
   logic [8:0]  o_pixel_y;
   logic [15:0] o_pixel_data;
   logic        o_pixel_write;
   logic        i_pixel_ready;

   modport slave (
      input  i_start, i_sprite_id, i_x_pos, i_y_pos, i_rom_data, i_pixel_ready,
      output o_busy, o_done, o_rom_id, o_rom_addr,
             o_pixel_x, o_pixel_y, o_pixel_data, o_pixel_write
   );

   modport master (
      output i_start, i_sprite_id, i_x_pos, i_y_pos, i_rom_data, i_pixel_ready,
      input  o_busy, o_done, o_rom_id, o_rom_addr,
             o_pixel_x, o_pixel_y, o_pixel_data, o_pixel_write
   );
endinterface

`default_nettype wire

// File: rtl/sprite_blitter.sv
// sprite_blitter: reads a sprite from ROM in raster order and writes its visible,
// non-transparent pixels to the LCD with clipping. Revision 1.0
`default_nettype none

module sprite_blitter #(
   parameter int          SPRITE_W     = 32,
   parameter int          SPRITE_H     = 32,
   parameter int          SCREEN_W     = 240,
   parameter int          SCREEN_H     = 320,
   parameter logic [15:0] TRANS_COLOUR = 16'hF81F,
   parameter int          READ_LATENCY = 2
) (
   input  wire logic       i_clk,
   input  wire logic       i_rst_n,
   sprite_blitter_if.slave bus
);

   localparam int COL_W     = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int WAIT_W    = $clog2(READ_LATENCY + 1);
   // READ_LATENCY must be at least 2: FETCH covers one cycle, WAIT the rest.
   localparam int WAIT_LAST = (READ_LATENCY > 2) ? READ_LATENCY - 2 : 0;

   localparam logic [8:0]       C_SCREEN_W = 9'(SCREEN_W);
   localparam logic [9:0]       C_SCREEN_H = 10'(SCREEN_H);
   localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(SPRITE_W - 1);
   localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(SPRITE_H - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [3:0]        r_id;
   logic [7:0]        r_x;
   logic [8:0]        r_y;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [15:0]       r_addr;
   logic [WAIT_W-1:0] r_wait;
   logic [7:0]        r_px;
   logic [8:0]        r_py;
   logic [15:0]       r_pd;
   logic              r_pw;

   logic [8:0]        w_sum_x;
   logic [9:0]        w_sum_y;
   logic              w_skip;
   logic              w_wait_end;
   logic              w_last_pix;
   logic              w_retire;

   always_comb begin
      w_sum_x      = {1'b0, r_x} + 9'(r_col);
      w_sum_y      = {1'b0, r_y} + 10'(r_row);
      w_skip       = (bus.i_rom_data == TRANS_COLOUR) || (w_sum_x >= C_SCREEN_W) ||
                     (w_sum_y >= C_SCREEN_H);
      w_wait_end   = (r_wait == WAIT_W'(WAIT_LAST));
      w_last_pix   = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);
      w_retire     = ((r_state == WAIT) && w_wait_end && w_skip) ||
                     ((r_state == WRITE) && bus.i_pixel_ready);
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.i_start) w_next_state = FETCH;
         FETCH:   w_next_state = WAIT;
         WAIT:    if (w_wait_end) w_next_state = w_skip ? (w_last_pix ? DONE : FETCH) : WRITE;
         WRITE:   if (bus.i_pixel_ready) w_next_state = w_last_pix ? DONE : FETCH;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_id    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_addr  <= '0;
         r_wait  <= '0;
         r_px    <= '0;
         r_py    <= '0;
         r_pd    <= '0;
         r_pw    <= 1'b0;
      end else begin
         r_state <= w_next_state;

         if ((r_state == IDLE) && bus.i_start) begin
            r_id   <= bus.i_sprite_id;
            r_x    <= bus.i_x_pos;
            r_y    <= bus.i_y_pos;
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
            r_wait <= '0;
         end

         if (r_state == WAIT) begin
            if (w_wait_end) begin
               r_wait <= '0;
               r_pd   <= bus.i_rom_data;
               r_px   <= w_sum_x[7:0];
               r_py   <= w_sum_y[8:0];
               r_pw   <= !w_skip;
            end else begin
               r_wait <= r_wait + WAIT_W'(1);
            end
         end

         if ((r_state == WRITE) && bus.i_pixel_ready) begin
            r_pw <= 1'b0;
         end

         // Address stays at the final word once the sprite is finished.
         if (w_retire) begin
            if (r_col == C_COL_LAST) begin
               r_col <= '0;
               r_row <= r_row + ROW_W'(1);
            end else begin
               r_col <= r_col + COL_W'(1);
            end
            if (!w_last_pix) begin
               r_addr <= r_addr + 16'd1;
            end
         end
      end
   end

   assign bus.o_rom_id      = r_id;
   assign bus.o_rom_addr    = r_addr;
   assign bus.o_pixel_x     = r_px;
   assign bus.o_pixel_y     = r_py;
   assign bus.o_pixel_data  = r_pd;
   assign bus.o_pixel_write = r_pw;
   assign bus.o_busy        = (r_state != IDLE);
   assign bus.o_done        = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed tests of sprite_blitter against a raster-order pixel model.
// Revision 1.0
`default_nettype none

module tb_sprite_blitter;

   localparam logic [15:0] TRANS = 16'hF81F;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sprite_blitter_if bif();

   sprite_blitter #(
      .SPRITE_W(32), .SPRITE_H(32), .SCREEN_W(240), .SCREEN_H(320),
      .TRANS_COLOUR(TRANS), .READ_LATENCY(2)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bif.slave)
   );

   int   nvec = 0;
   int   nfail = 0;
   int   wr_cnt = 0;
   int   done_cnt = 0;
   pix_t first_w, last_w;
   pix_t exp_q[$];
   logic [3:0] exp_id = '0;

   function automatic logic [15:0] rom_word(input logic [3:0] id, input int addr);
      logic [15:0] a;
      a = 16'(addr);
      case (id)
         4'd2:    return (addr < 32) ? TRANS : {4'h2, a[11:0]};
         4'd3:    return ((addr % 7) == 3) ? TRANS : {4'h3, a[11:0]};
         default: return {id, a[11:0]};
      endcase
   endfunction

   // ROM read stage: data follows the address by two clock edges.
   logic [15:0] rom_q = '0;
   always @(posedge clk) rom_q <= rom_word(bif.o_rom_id, int'(bif.o_rom_addr));
   assign bif.i_rom_data = rom_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bif.o_done) done_cnt++;
         if (bif.o_busy) chk("rom_id", 64'(bif.o_rom_id), 64'(exp_id));
         if (bif.o_pixel_write) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL extra_write actual=(%0d,%0d,%0h) required=none",
                        bif.o_pixel_x, bif.o_pixel_y, bif.o_pixel_data);
            end else begin
               chk("pixel", 64'({bif.o_pixel_x, bif.o_pixel_y, bif.o_pixel_data}),
                   64'(exp_q[0]));
               if (bif.i_pixel_ready) begin
                  if (wr_cnt == 0) first_w = exp_q[0];
                  last_w = exp_q[0];
                  wr_cnt++;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic start_sprite(input logic [3:0] id, input int x, input int y);
      exp_q.delete();
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            logic [15:0] d;
            d = rom_word(id, r * 32 + c);
            if (d != TRANS && x + c < 240 && y + r < 320)
               exp_q.push_back('{x: 8'(x + c), y: 9'(y + r), d: d});
         end
      end
      exp_id   = id;
      wr_cnt   = 0;
      done_cnt = 0;
      bif.i_start     = 1'b1;
      bif.i_sprite_id = id;
      bif.i_x_pos     = 8'(x);
      bif.i_y_pos     = 9'(y);
      @(posedge clk); #1;
      bif.i_start = 1'b0;
      chk("busy_after_start", 64'(bif.o_busy), 64'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 8000; i++) begin
         @(posedge clk);
         if (done_cnt > 0) break;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("busy_after_done", 64'(bif.o_busy), 64'd0);
      chk("model_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pw"},   64'(bif.o_pixel_write), 64'd0);
      chk({tag, "_busy"}, 64'(bif.o_busy), 64'd0);
      chk({tag, "_done"}, 64'(bif.o_done), 64'd0);
      chk({tag, "_rom"},  64'({bif.o_rom_id, bif.o_rom_addr}), 64'd0);
      chk({tag, "_pix"},  64'({bif.o_pixel_x, bif.o_pixel_y, bif.o_pixel_data}), 64'd0);
   endtask

   initial begin
      pix_t snap;
      bif.i_start       = 1'b0;
      bif.i_sprite_id   = '0;
      bif.i_x_pos       = '0;
      bif.i_y_pos       = '0;
      bif.i_pixel_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Opaque sprite
      start_sprite(4'd1, 10, 20);
      wait_done();
      chk("opaque_count", 64'(wr_cnt), 64'd1024);
      chk("opaque_first", 64'(first_w), 64'({8'd10, 9'd20, 16'h1000}));
      chk("opaque_last",  64'(last_w),  64'({8'd41, 9'd51, 16'h13FF}));

      // Transparent first row
      start_sprite(4'd2, 10, 20);
      wait_done();
      chk("trans_count", 64'(wr_cnt), 64'd992);
      chk("trans_first", 64'(first_w), 64'({8'd10, 9'd21, 16'h2020}));

      // Clipped at bottom-right corner
      start_sprite(4'd1, 230, 300);
      wait_done();
      chk("clip_count", 64'(wr_cnt), 64'd200);
      chk("clip_first", 64'(first_w), 64'({8'd230, 9'd300, 16'h1000}));
      chk("clip_last",  64'(last_w),  64'({8'd239, 9'd319, 16'h1269}));

      // Back-pressure on the first pixel
      bif.i_pixel_ready = 1'b0;
      start_sprite(4'd3, 0, 0);
      for (int i = 0; i < 20 && !bif.o_pixel_write; i++) @(negedge clk);
      chk("stall_pw_seen", 64'(bif.o_pixel_write), 64'd1);
      snap = '{x: bif.o_pixel_x, y: bif.o_pixel_y, d: bif.o_pixel_data};
      chk("stall_snap", 64'(snap), 64'({8'd0, 9'd0, 16'h3000}));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_pw_held", 64'(bif.o_pixel_write), 64'd1);
         chk("stall_hold", 64'({bif.o_pixel_x, bif.o_pixel_y, bif.o_pixel_data}), 64'(snap));
      end
      @(posedge clk); #1;
      bif.i_pixel_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_pw_drop", 64'(bif.o_pixel_write), 64'd0);
      chk("stall_one_xfer", 64'(wr_cnt), 64'd1);
      wait_done();
      chk("stall_count", 64'(wr_cnt), 64'd878);

      // Reset while a write is pending
      start_sprite(4'd1, 5, 5);
      for (int i = 0; i < 500 && wr_cnt < 40; i++) @(posedge clk);
      #1;
      bif.i_pixel_ready = 1'b0;
      for (int i = 0; i < 20 && !bif.o_pixel_write; i++) @(negedge clk);
      chk("rst_pw_pending", 64'(bif.o_pixel_write), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      exp_q.delete();
      bif.i_pixel_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start_sprite(4'd1, 5, 5);
      wait_done();
      chk("rst_redraw_count", 64'(wr_cnt), 64'd1024);
      chk("rst_redraw_first", 64'(first_w), 64'({8'd5, 9'd5, 16'h1000}));

      // Start pulse while busy must be ignored
      start_sprite(4'd3, 100, 100);
      repeat (50) @(posedge clk);
      #1;
      bif.i_start     = 1'b1;
      bif.i_sprite_id = 4'd2;
      bif.i_x_pos     = 8'd0;
      bif.i_y_pos     = 9'd0;
      @(posedge clk); #1;
      bif.i_start = 1'b0;
      wait_done();
      chk("busy_start_count", 64'(wr_cnt), 64'd878);
      chk("busy_start_last", 64'(last_w), 64'({8'd131, 9'd131, 16'h33FF}));
      repeat (10) @(posedge clk);
      #1;
      chk("busy_start_idle", 64'({bif.o_busy, 4'(done_cnt)}), 64'({1'b0, 4'd1}));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

`default_nettype wire
